ring_host_stop: RTL

Ring stop inserted between a tile's ring output and the next tile's ring input; it gives an external host agent (loader/debug) access to the ring. Passing ring traffic is re-registered one stage (Q502H to Q503H). Host requests are buffered in a FIFO and injected only into empty ring slots. Read responses addressed to the host are removed from the ring and presented on a host response port.

---
 rtl/lotr_pkg.sv | 20 ++
 rtl/ring_host_fifo.sv | 73 +++++++
 rtl/ring_host_stop.sv | 127 ++++++++++++
 3 files changed

// File: rtl/lotr_pkg.sv
// Shared ring types for the lotr tile ring.
// Opcodes, slot bundle and host ring ID.
package lotr_pkg;

  typedef enum logic [1:0] {
    RD      = 2'b00,
    RD_RSP  = 2'b01,
    WR      = 2'b10,
    WR_BCST = 2'b11
  } t_opcode;

  localparam logic [7:0] HOST_ID_DEFAULT = 8'hFF;

  typedef struct packed {
    t_opcode     opcode;
    logic [31:0] address;
    logic [31:0] data;
  } t_ring_slot;

endpackage

// File: rtl/ring_host_fifo.sv
// Host request FIFO for the ring host stop.
// Power-of-two depth, registered full/empty/count.
import lotr_pkg::*;

module ring_host_fifo #(
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  t_ring_slot    push_data,
  input  logic          pop,
  output t_ring_slot    pop_data,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  t_ring_slot    mem_q [DEPTH];
  t_ring_slot    mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push;
  logic          do_pop;

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    if (do_push && !do_pop) begin
      count_d = count_q + CW'(1);
    end else if (do_pop && !do_push) begin
      count_d = count_q - CW'(1);
    end
  end

  // FIFO state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/ring_host_stop.sv
// Ring stop giving a host agent access to the ring.
// Ejects host read responses, injects queued requests into idle slots.
import lotr_pkg::*;

module ring_host_stop #(
  parameter  int         FIFO_DEPTH = 4,
  parameter  logic [7:0] HOST_ID    = HOST_ID_DEFAULT,
  localparam int         CW         = $clog2(FIFO_DEPTH + 1)
) (
  input  logic          QClk,
  input  logic          RstQnnnL,
  input  logic          RingInputValidQ502H,
  input  t_opcode       RingInputOpcodeQ502H,
  input  logic [31:0]   RingInputAddressQ502H,
  input  logic [31:0]   RingInputDataQ502H,
  output logic          RingOutputValidQ503H,
  output t_opcode       RingOutputOpcodeQ503H,
  output logic [31:0]   RingOutputAddressQ503H,
  output logic [31:0]   RingOutputDataQ503H,
  input  logic          HostReqValid,
  output logic          HostReqReady,
  input  t_opcode       HostReqOpcode,
  input  logic [31:0]   HostReqAddress,
  input  logic [31:0]   HostReqData,
  output logic          HostRspValid,
  input  logic          HostRspReady,
  output logic [31:0]   HostRspAddress,
  output logic [31:0]   HostRspData,
  output logic [CW-1:0] HostFifoCount
);

  t_ring_slot  in_slot;
  t_ring_slot  req_slot;
  t_ring_slot  head_slot;
  t_ring_slot  out_q, out_d;
  logic        out_valid_q, out_valid_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_addr_q, rsp_addr_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic        fifo_full;
  logic        fifo_empty;
  logic        fifo_push;
  logic        fifo_pop;
  logic        host_hit;
  logic        rsp_drain;
  logic        eject;
  logic        fwd;

  assign in_slot  = '{opcode:  RingInputOpcodeQ502H,
                      address: RingInputAddressQ502H,
                      data:    RingInputDataQ502H};
  assign req_slot = '{opcode:  HostReqOpcode,
                      address: HostReqAddress,
                      data:    HostReqData};

  ring_host_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (QClk),
    .rst_n     (RstQnnnL),
    .push      (fifo_push),
    .push_data (req_slot),
    .pop       (fifo_pop),
    .pop_data  (head_slot),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (HostFifoCount)
  );

  // Eject/forward/inject selection and response buffer update.
  always_comb begin
    host_hit = RingInputValidQ502H
            && (RingInputOpcodeQ502H == RD_RSP)
            && (RingInputAddressQ502H[31:24] == HOST_ID);
    rsp_drain = rsp_valid_q && HostRspReady;
    eject     = host_hit && (!rsp_valid_q || rsp_drain);
    fwd       = RingInputValidQ502H && !eject;
    fifo_pop  = !fwd && !fifo_empty;
    fifo_push = HostReqValid && !fifo_full;

    out_valid_d = 1'b0;
    out_d       = '0;
    if (fwd) begin
      out_valid_d = 1'b1;
      out_d       = in_slot;
    end else if (fifo_pop) begin
      out_valid_d = 1'b1;
      out_d       = head_slot;
    end

    rsp_valid_d = rsp_valid_q && !rsp_drain;
    rsp_addr_d  = rsp_addr_q;
    rsp_data_d  = rsp_data_q;
    if (eject) begin
      rsp_valid_d = 1'b1;
      rsp_addr_d  = RingInputAddressQ502H;
      rsp_data_d  = RingInputDataQ502H;
    end
  end

  // Q503H ring output and host response registers.
  always_ff @(posedge QClk or negedge RstQnnnL) begin
    if (!RstQnnnL) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_addr_q  <= '0;
      rsp_data_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_addr_q  <= rsp_addr_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign RingOutputValidQ503H   = out_valid_q;
  assign RingOutputOpcodeQ503H  = out_q.opcode;
  assign RingOutputAddressQ503H = out_q.address;
  assign RingOutputDataQ503H    = out_q.data;
  assign HostReqReady           = !fifo_full;
  assign HostRspValid           = rsp_valid_q;
  assign HostRspAddress         = rsp_addr_q;
  assign HostRspData            = rsp_data_q;

endmodule
